inst_fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of decode and immediate generation. Owns the fetch PC and issues word-aligned requests to instruction memory. Buffers in-order responses in a small queue and presents one instruction plus its PC per cycle to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and squash in-flight responses.

---
 rtl/inst_fetch_queue_pkg.sv | 15 +
 rtl/inst_fetch_queue_sync_fifo.sv | 41 ++++
 rtl/inst_fetch_queue.sv | 96 +++++++++
 tb/tb_inst_fetch_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end.
// Covers the NOP encoding, the FSM state codes and the fetch queue entry layout.
package inst_fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// The head is read combinationally from storage. When the FIFO is full, a pop frees the slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited requests and queues in-order responses.
// Redirects flush the queue and discard the responses that are still in flight.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding, out_dec, discard, discard_nxt, count;
  logic [CW:0]     credit;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [PW-1:0]   pcq_wp, pcq_rp;
  logic            req_fire, push, pop;
  fetch_entry_t    wr_ent, head;

  assign credit         = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (state != BOOT) && !redirect_valid && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_dec        = outstanding - CW'(imem_rsp_valid);

  // A redirect wins over same-cycle push/pop; the clear drops the whole queue.
  assign push   = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop    = inst_valid && inst_ready && !redirect_valid;
  assign wr_ent = '{inst: imem_rsp_data, pc: pcq[pcq_rp]};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (wr_ent),
    .rdata (head),
    .count (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc : '0;

  // Responses to requests issued before a redirect still arrive and must be counted off.
  always_comb begin
    discard_nxt = discard;
    if (redirect_valid)                      discard_nxt = out_dec;
    else if (imem_rsp_valid && discard != '0) discard_nxt = discard - CW'(1);
    state_nxt = (discard_nxt != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      pcq_wp      <= '0;
      pcq_rp      <= '0;
    end else begin
      state       <= state_nxt;
      discard     <= discard_nxt;
      outstanding <= out_dec + CW'(req_fire);
      if (imem_rsp_valid) pcq_rp <= pcq_rp + PW'(1);
      if (req_fire) pcq_wp <= pcq_wp + PW'(1);
      if (redirect_valid)  fetch_pc <= redirect_pc & ~XLEN'(3);
      else if (req_fire)   fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // PC of every accepted request, consumed in order as responses return.
  always_ff @(posedge clk) begin
    if (!rst && req_fire) pcq[pcq_wp] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(imem_rsp_valid && outstanding == '0));
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model with variable latency, scoreboard on delivered instructions,
// and directed per-cycle checks of the request and head outputs.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b1;
  logic [31:0] inst, inst_pc;

  inst_fetch_queue #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, delivered = 0, cyc = 0, lat = 1;
  fetch_entry_t sb[$];
  fetch_entry_t mon_e;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] pc, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      sb.push_back('{inst: mw(pc), pc: pc});
      pc += 32'd4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic row(input string tag, input logic rv, input logic [31:0] a,
                     input logic iv, input logic [31:0] pc);
    #3;
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(rv));
    chk({tag, ".req_addr"}, imem_req_addr, a);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(iv));
    chk({tag, ".inst_pc"}, inst_pc, pc);
    chk({tag, ".inst"}, inst, iv ? mw(pc) : NOP_INST);
  endtask

  task automatic do_reset(input logic rdy, input int l);
    tick(); rst = 1'b1; redirect_valid = 1'b0; inst_ready = rdy; lat = l;
    tick(); tick(); rst = 1'b0;
    expect_stream(32'h0, 32);
    row("reset", 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // memory: in-order, responds lat cycles after acceptance
  initial begin
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(negedge clk); #1; cyc++;
      if (rst) begin
        pend.delete(); imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1'b1; imem_rsp_data = mw(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        end
        if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
      end
    end
  end

  // monitor: every consumed head must match the scoreboard
  initial forever begin
    @(negedge clk); #2;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      delivered++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra: got pc %h want none", inst_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc", inst_pc, mon_e.pc);
        chk("sb_inst", inst, mon_e.inst);
      end
    end
  end

  initial begin
    // basic flow, latency 1, decode always ready
    do_reset(1'b1, 1);
    tick(); row("t1_c1", 1, 32'h0, 0, 32'h0);
    tick(); row("t1_c2", 1, 32'h4, 0, 32'h0);
    tick(); row("t1_c3", 0, 32'h8, 1, 32'h0);
    tick(); row("t1_c4", 1, 32'h8, 1, 32'h4);
    tick(); row("t1_c5", 1, 32'hC, 0, 32'h0);
    // redirect with a response arriving and a head being consumed
    tick(); redirect_valid = 1; redirect_pc = 32'h203; expect_stream(32'h200, 32);
    row("t4_rd", 0, 32'h10, 1, 32'h8);
    tick(); redirect_valid = 0; row("t4_c1", 1, 32'h200, 0, 32'h0);
    tick(); row("t4_c2", 1, 32'h204, 0, 32'h0);
    tick(); row("t4_c3", 0, 32'h208, 1, 32'h200);
    repeat (6) tick();

    // decode stalled: credits fill, then resume
    do_reset(1'b0, 1);
    tick(); row("t2_c1", 1, 32'h0, 0, 32'h0);
    tick(); row("t2_c2", 1, 32'h4, 0, 32'h0);
    tick(); row("t2_c3", 0, 32'h8, 1, 32'h0);
    tick(); row("t2_c4", 0, 32'h8, 1, 32'h0);
    tick(); row("t2_c5", 0, 32'h8, 1, 32'h0);
    tick(); inst_ready = 1; row("t2_go", 0, 32'h8, 1, 32'h0);
    tick(); row("t2_c7", 1, 32'h8, 1, 32'h4);
    repeat (6) tick();

    // redirect with two requests in flight, latency 3
    do_reset(1'b1, 3);
    tick(); row("t3_c1", 1, 32'h0, 0, 32'h0);
    tick(); row("t3_c2", 1, 32'h4, 0, 32'h0);
    tick(); redirect_valid = 1; redirect_pc = 32'h100; expect_stream(32'h100, 32);
    row("t3_rd", 0, 32'h8, 0, 32'h0);
    tick(); redirect_valid = 0; row("t3_c4", 0, 32'h100, 0, 32'h0);
    tick(); row("t3_c5", 1, 32'h100, 0, 32'h0);
    tick(); row("t3_c6", 1, 32'h104, 0, 32'h0);
    repeat (8) tick();

    // back-to-back redirects, last one wins
    lat = 1;
    repeat (6) tick();
    tick(); redirect_valid = 1; redirect_pc = 32'h300; expect_stream(32'h300, 32);
    #3 chk("t5_rd1.req_valid", 32'(imem_req_valid), 32'h0);
    tick(); redirect_pc = 32'h400; expect_stream(32'h400, 32);
    #3 chk("t5_rd2.req_valid", 32'(imem_req_valid), 32'h0);
    tick(); redirect_valid = 0; row("t5_c1", 1, 32'h400, 0, 32'h0);
    repeat (8) tick();

    // fetch PC wraps at the top of the address space
    tick(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF; expect_stream(32'hFFFF_FFFC, 32);
    tick(); redirect_valid = 0; row("t6_c1", 1, 32'hFFFF_FFFC, 0, 32'h0);
    tick(); row("t6_c2", 1, 32'h0, 0, 32'h0);
    repeat (8) tick();

    // reset while draining
    lat = 3;
    repeat (6) tick();
    tick(); redirect_valid = 1; redirect_pc = 32'h500; expect_stream(32'h500, 32);
    tick(); redirect_valid = 0; rst = 1;
    tick(); rst = 0; expect_stream(32'h0, 32);
    row("t7_rst", 0, 32'h0, 0, 32'h0);
    tick(); row("t7_c1", 1, 32'h0, 0, 32'h0);
    repeat (12) tick();

    tick();
    chk("min_deliveries", 32'(delivered >= 15), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
